// File: rtl/ex_stage_if.sv
// Execute-stage bus: ID/EX-side operands and control in, EX/MEM register contents out.
// master is the surrounding pipeline; slave is ex_stage.
interface ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              memWrite_E, memRead_E, regWrite_E;
  logic [1:0]        write_back_E;
  logic [3:0]        alu_ctrl_E;
  logic              alu_srcB_E;
  logic              jump_E, jumpReg_E;
  logic [2:0]        branch_E;
  logic              branch0_E;
  logic [DATA_W-1:0] pc_E, pc4_E, imm_extended_E, RD1_E, RD2_E;
  logic [REG_W-1:0]  rs1_E, rs2_E, rd_E;
  logic [2:0]        mode_E;
  logic [1:0]        forwardA_E, forwardB_E;
  logic [DATA_W-1:0] result_W;
  logic              StallM, FlushM;

  logic              pc_src_E;
  logic [DATA_W-1:0] pc_target_E;
  logic              memWrite_M, memRead_M, regWrite_M;
  logic [1:0]        write_back_M;
  logic [DATA_W-1:0] alu_result_M, write_data_M, pc4_M;
  logic [REG_W-1:0]  rd_M;
  logic [2:0]        mode_M;

  modport master (
    output memWrite_E, memRead_E, regWrite_E, write_back_E, alu_ctrl_E, alu_srcB_E,
           jump_E, jumpReg_E, branch_E, branch0_E, pc_E, pc4_E, imm_extended_E,
           RD1_E, RD2_E, rs1_E, rs2_E, rd_E, mode_E, forwardA_E, forwardB_E,
           result_W, StallM, FlushM,
    input  pc_src_E, pc_target_E, memWrite_M, memRead_M, regWrite_M, write_back_M,
           alu_result_M, write_data_M, pc4_M, rd_M, mode_M
  );

  modport slave (
    input  memWrite_E, memRead_E, regWrite_E, write_back_E, alu_ctrl_E, alu_srcB_E,
           jump_E, jumpReg_E, branch_E, branch0_E, pc_E, pc4_E, imm_extended_E,
           RD1_E, RD2_E, rs1_E, rs2_E, rd_E, mode_E, forwardA_E, forwardB_E,
           result_W, StallM, FlushM,
    output pc_src_E, pc_target_E, memWrite_M, memRead_M, regWrite_M, write_back_M,
           alu_result_M, write_data_M, pc4_M, rd_M, mode_M
  );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
module ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave bus
);
  logic [DATA_W-1:0] src_a, fwd_b, src_b, alu_out;
  logic [4:0]        shamt;
  logic              cond;

  always_comb begin
    case (bus.forwardA_E)
      2'b01:   src_a = bus.result_W;
      2'b10:   src_a = bus.alu_result_M;
      default: src_a = bus.RD1_E;
    endcase
    case (bus.forwardB_E)
      2'b01:   fwd_b = bus.result_W;
      2'b10:   fwd_b = bus.alu_result_M;
      default: fwd_b = bus.RD2_E;
    endcase
  end

  assign src_b = bus.alu_srcB_E ? bus.imm_extended_E : fwd_b;
  assign shamt = src_b[4:0];

  always_comb begin
    alu_out = '0;
    case (bus.alu_ctrl_E)
      4'b0000: alu_out = src_a + src_b;
      4'b0001: alu_out = src_a - src_b;
      4'b0010: alu_out = src_a & src_b;
      4'b0011: alu_out = src_a | src_b;
      4'b0100: alu_out = src_a ^ src_b;
      4'b0101: alu_out = src_a << shamt;
      4'b0110: alu_out = src_a >> shamt;
      4'b0111: alu_out = $unsigned($signed(src_a) >>> shamt);
      4'b1000: alu_out = {{(DATA_W-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'b1001: alu_out = {{(DATA_W-1){1'b0}}, src_a < src_b};
      4'b1010: alu_out = src_b;
      4'b1011: alu_out = bus.pc_E + bus.imm_extended_E;
      default: alu_out = '0;
    endcase
  end

  // Branches compare the forwarded rs2 value, never the immediate.
  always_comb begin
    cond = 1'b0;
    case (bus.branch_E)
      3'b000:  cond = (src_a == fwd_b);
      3'b001:  cond = (src_a != fwd_b);
      3'b100:  cond = ($signed(src_a) <  $signed(fwd_b));
      3'b101:  cond = ($signed(src_a) >= $signed(fwd_b));
      3'b110:  cond = (src_a <  fwd_b);
      3'b111:  cond = (src_a >= fwd_b);
      default: cond = 1'b0;
    endcase
  end

  logic [DATA_W-1:0] jalr_sum;
  assign jalr_sum        = src_a + bus.imm_extended_E;
  assign bus.pc_src_E    = bus.jump_E | bus.jumpReg_E | (bus.branch0_E & cond);
  assign bus.pc_target_E = bus.jumpReg_E ? {jalr_sum[DATA_W-1:1], 1'b0}
                                         : bus.pc_E + bus.imm_extended_E;

  // A flushed slot is all zeros, so it can never write memory or the register file.
  always_ff @(posedge clk) begin
    if (rst || bus.FlushM) begin
      bus.memWrite_M   <= 1'b0;
      bus.memRead_M    <= 1'b0;
      bus.regWrite_M   <= 1'b0;
      bus.write_back_M <= '0;
      bus.alu_result_M <= '0;
      bus.write_data_M <= '0;
      bus.pc4_M        <= '0;
      bus.rd_M         <= '0;
      bus.mode_M       <= '0;
    end else if (!bus.StallM) begin
      bus.memWrite_M   <= bus.memWrite_E;
      bus.memRead_M    <= bus.memRead_E;
      bus.regWrite_M   <= bus.regWrite_E;
      bus.write_back_M <= bus.write_back_E;
      bus.alu_result_M <= alu_out;
      bus.write_data_M <= fwd_b;
      bus.pc4_M        <= bus.pc4_E;
      bus.rd_M         <= bus.rd_E;
      bus.mode_M       <= bus.mode_E;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: reset, ALU ops, forwarding, branches, jumps, stall/flush.
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  ex_stage_if bus ();
  ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.memWrite_E = 0; bus.memRead_E = 0; bus.regWrite_E = 0; bus.write_back_E = 0;
    bus.alu_ctrl_E = 0; bus.alu_srcB_E = 0; bus.jump_E = 0; bus.jumpReg_E = 0;
    bus.branch_E = 3'b010; bus.branch0_E = 0; bus.pc_E = 0; bus.pc4_E = 0;
    bus.imm_extended_E = 0; bus.RD1_E = 0; bus.RD2_E = 0; bus.rs1_E = 0; bus.rs2_E = 0;
    bus.rd_E = 0; bus.mode_E = 0; bus.forwardA_E = 0; bus.forwardB_E = 0;
    bus.result_W = 0; bus.StallM = 0; bus.FlushM = 0;
  endtask

  task automatic random_inputs();
    bus.memWrite_E = 1; bus.memRead_E = 1; bus.regWrite_E = 1; bus.write_back_E = 2'b11;
    bus.alu_ctrl_E = 4'($urandom_range(0, 11)); bus.alu_srcB_E = 1'($urandom);
    bus.pc_E = $urandom; bus.pc4_E = $urandom; bus.imm_extended_E = $urandom;
    bus.RD1_E = $urandom | 32'h1; bus.RD2_E = $urandom | 32'h1; bus.rd_E = 5'h1f;
    bus.mode_E = 3'b111; bus.result_W = $urandom;
  endtask

  task automatic test_reset();
    rst = 1; random_inputs();
    tick(); random_inputs(); tick();
    checks++; if ({bus.memWrite_M, bus.memRead_M, bus.regWrite_M} !== 3'b000) begin fails++;
      $display("FAIL reset_ctrl: got %b want 000", {bus.memWrite_M, bus.memRead_M, bus.regWrite_M}); end
    checks++; if (bus.alu_result_M !== 32'h0) begin fails++;
      $display("FAIL reset_alu: got %h want 0", bus.alu_result_M); end
    checks++; if ({bus.write_data_M, bus.pc4_M} !== 64'h0) begin fails++;
      $display("FAIL reset_data: got %h %h want 0", bus.write_data_M, bus.pc4_M); end
    checks++; if ({bus.rd_M, bus.mode_M, bus.write_back_M} !== 10'h0) begin fails++;
      $display("FAIL reset_misc: got %h %h %h want 0", bus.rd_M, bus.mode_M, bus.write_back_M); end
    rst = 0;
  endtask

  task automatic test_add();
    idle_inputs();
    bus.alu_ctrl_E = 4'b0000; bus.RD1_E = 5; bus.RD2_E = 7; bus.rd_E = 3; bus.regWrite_E = 1;
    bus.write_back_E = 2'b01; bus.mode_E = 3'b010;
    tick();
    checks++; if (bus.alu_result_M !== 32'd12) begin fails++;
      $display("FAIL add_result: got %h want c", bus.alu_result_M); end
    checks++; if (bus.write_data_M !== 32'd7) begin fails++;
      $display("FAIL add_wdata: got %h want 7", bus.write_data_M); end
    checks++; if ({bus.regWrite_M, bus.rd_M, bus.write_back_M, bus.mode_M} !== {1'b1, 5'd3, 2'b01, 3'b010}) begin fails++;
      $display("FAIL add_ctrl: got %b %h %b %b", bus.regWrite_M, bus.rd_M, bus.write_back_M, bus.mode_M); end
  endtask

  task automatic test_forward();
    idle_inputs();
    bus.alu_ctrl_E = 4'b0001; bus.forwardA_E = 2'b10; bus.forwardB_E = 2'b01;
    bus.result_W = 3; bus.RD1_E = 32'hdead; bus.RD2_E = 32'hbeef;
    tick();
    checks++; if (bus.alu_result_M !== 32'd9) begin fails++;
      $display("FAIL fwd_sub: got %h want 9", bus.alu_result_M); end
    checks++; if (bus.write_data_M !== 32'd3) begin fails++;
      $display("FAIL fwd_wdata: got %h want 3", bus.write_data_M); end
    // forward code 11 selects the register file value
    idle_inputs();
    bus.alu_ctrl_E = 4'b0000; bus.forwardA_E = 2'b11; bus.forwardB_E = 2'b11;
    bus.RD1_E = 32'h10; bus.RD2_E = 32'h20; bus.result_W = 32'h999;
    tick();
    checks++; if (bus.alu_result_M !== 32'h30) begin fails++;
      $display("FAIL fwd_11: got %h want 30", bus.alu_result_M); end
  endtask

  task automatic test_alu();
    idle_inputs();
    bus.alu_ctrl_E = 4'b0111; bus.RD1_E = 32'h8000_0000; bus.imm_extended_E = 4;
    bus.alu_srcB_E = 1; bus.RD2_E = 32'h0000_abcd;
    tick();
    checks++; if (bus.alu_result_M !== 32'hf800_0000) begin fails++;
      $display("FAIL sra: got %h want f8000000", bus.alu_result_M); end
    checks++; if (bus.write_data_M !== 32'h0000_abcd) begin fails++;
      $display("FAIL wdata_not_imm: got %h want abcd", bus.write_data_M); end
    bus.alu_ctrl_E = 4'b0110; tick();
    checks++; if (bus.alu_result_M !== 32'h0800_0000) begin fails++;
      $display("FAIL srl: got %h want 08000000", bus.alu_result_M); end
    idle_inputs();
    bus.alu_ctrl_E = 4'b1001; bus.RD1_E = 1; bus.RD2_E = 32'hffff_ffff; tick();
    checks++; if (bus.alu_result_M !== 32'd1) begin fails++;
      $display("FAIL sltu: got %h want 1", bus.alu_result_M); end
    bus.alu_ctrl_E = 4'b1000; tick();
    checks++; if (bus.alu_result_M !== 32'd0) begin fails++;
      $display("FAIL slt: got %h want 0", bus.alu_result_M); end
    bus.alu_ctrl_E = 4'b0000; bus.RD1_E = 32'hffff_ffff; bus.RD2_E = 2; tick();
    checks++; if (bus.alu_result_M !== 32'd1) begin fails++;
      $display("FAIL add_wrap: got %h want 1", bus.alu_result_M); end
    bus.alu_ctrl_E = 4'b0101; bus.RD1_E = 32'h3; bus.RD2_E = 32'h24; tick();
    checks++; if (bus.alu_result_M !== 32'h30) begin fails++;
      $display("FAIL sll_mask: got %h want 30", bus.alu_result_M); end
    bus.alu_ctrl_E = 4'b0100; bus.RD1_E = 32'hf0f0; bus.RD2_E = 32'hff00; tick();
    checks++; if (bus.alu_result_M !== 32'h0ff0) begin fails++;
      $display("FAIL xor: got %h want ff0", bus.alu_result_M); end
    bus.alu_ctrl_E = 4'b1010; bus.alu_srcB_E = 1; bus.imm_extended_E = 32'h1234_5000; tick();
    checks++; if (bus.alu_result_M !== 32'h1234_5000) begin fails++;
      $display("FAIL lui: got %h want 12345000", bus.alu_result_M); end
    bus.alu_ctrl_E = 4'b1011; bus.pc_E = 32'h400; tick();
    checks++; if (bus.alu_result_M !== 32'h1234_5400) begin fails++;
      $display("FAIL auipc: got %h want 12345400", bus.alu_result_M); end
    bus.alu_ctrl_E = 4'b1100; tick();
    checks++; if (bus.alu_result_M !== 32'h0) begin fails++;
      $display("FAIL undef_op: got %h want 0", bus.alu_result_M); end
  endtask

  task automatic test_branch();
    idle_inputs();
    bus.branch0_E = 1; bus.branch_E = 3'b100; bus.RD1_E = 32'hffff_ffff; bus.RD2_E = 0;
    bus.pc_E = 32'h100; bus.imm_extended_E = 32'h20; #1;
    checks++; if (bus.pc_src_E !== 1'b1) begin fails++;
      $display("FAIL blt_taken: got %b want 1", bus.pc_src_E); end
    checks++; if (bus.pc_target_E !== 32'h120) begin fails++;
      $display("FAIL blt_target: got %h want 120", bus.pc_target_E); end
    bus.branch_E = 3'b110; #1;
    checks++; if (bus.pc_src_E !== 1'b0) begin fails++;
      $display("FAIL bltu: got %b want 0", bus.pc_src_E); end
    bus.branch_E = 3'b111; #1;
    checks++; if (bus.pc_src_E !== 1'b1) begin fails++;
      $display("FAIL bgeu: got %b want 1", bus.pc_src_E); end
    bus.RD2_E = 32'hffff_ffff; bus.branch_E = 3'b000; #1;
    checks++; if (bus.pc_src_E !== 1'b1) begin fails++;
      $display("FAIL beq: got %b want 1", bus.pc_src_E); end
    bus.branch_E = 3'b010; #1;
    checks++; if (bus.pc_src_E !== 1'b0) begin fails++;
      $display("FAIL br_010: got %b want 0", bus.pc_src_E); end
    bus.branch_E = 3'b000; bus.branch0_E = 0; #1;
    checks++; if (bus.pc_src_E !== 1'b0) begin fails++;
      $display("FAIL not_branch: got %b want 0", bus.pc_src_E); end
    // branch condition uses fwdB even when operand B is an immediate
    bus.branch0_E = 1; bus.branch_E = 3'b001; bus.alu_srcB_E = 1; bus.imm_extended_E = 32'h20; #1;
    checks++; if (bus.pc_src_E !== 1'b0) begin fails++;
      $display("FAIL bne_fwdb: got %b want 0", bus.pc_src_E); end
  endtask

  task automatic test_jalr();
    idle_inputs();
    bus.jumpReg_E = 1; bus.jump_E = 1; bus.RD1_E = 32'h1003; bus.imm_extended_E = 0;
    bus.pc_E = 32'h500; bus.pc4_E = 32'h504; bus.rd_E = 1; bus.regWrite_E = 1; #1;
    checks++; if (bus.pc_target_E !== 32'h1002) begin fails++;
      $display("FAIL jalr_target: got %h want 1002", bus.pc_target_E); end
    checks++; if (bus.pc_src_E !== 1'b1) begin fails++;
      $display("FAIL jalr_src: got %b want 1", bus.pc_src_E); end
    tick();
    checks++; if (bus.pc4_M !== 32'h504) begin fails++;
      $display("FAIL jalr_pc4: got %h want 504", bus.pc4_M); end
    bus.jumpReg_E = 0; bus.imm_extended_E = 32'h10; #1;
    checks++; if ({bus.pc_src_E, bus.pc_target_E} !== {1'b1, 32'h510}) begin fails++;
      $display("FAIL jal: got %b %h want 1 510", bus.pc_src_E, bus.pc_target_E); end
  endtask

  task automatic test_stall_flush();
    idle_inputs();
    bus.alu_ctrl_E = 0; bus.RD1_E = 1; bus.RD2_E = 2; bus.rd_E = 9; bus.memRead_E = 1;
    bus.mode_E = 3'd5; bus.pc4_E = 32'h44; bus.regWrite_E = 1; tick();
    bus.StallM = 1;
    for (int i = 0; i < 3; i++) begin
      bus.RD1_E = 32'(100 + i); bus.RD2_E = 32'(7 * i); bus.rd_E = 5'(i); bus.mode_E = 3'(i);
      bus.pc4_E = 32'(i); bus.memRead_E = 0; tick();
      checks++; if ({bus.alu_result_M, bus.write_data_M, bus.pc4_M} !== {32'd3, 32'd2, 32'h44}) begin fails++;
        $display("FAIL stall_data[%0d]: got %h %h %h want 3 2 44", i, bus.alu_result_M, bus.write_data_M, bus.pc4_M); end
      checks++; if ({bus.rd_M, bus.mode_M, bus.memRead_M, bus.regWrite_M} !== {5'd9, 3'd5, 1'b1, 1'b1}) begin fails++;
        $display("FAIL stall_ctrl[%0d]: got %h %h %b %b", i, bus.rd_M, bus.mode_M, bus.memRead_M, bus.regWrite_M); end
    end
    bus.FlushM = 1; bus.memWrite_E = 1; tick();
    checks++; if ({bus.regWrite_M, bus.memWrite_M, bus.memRead_M} !== 3'b000) begin fails++;
      $display("FAIL flush_ctrl: got %b want 000", {bus.regWrite_M, bus.memWrite_M, bus.memRead_M}); end
    checks++; if ({bus.alu_result_M, bus.write_data_M, bus.pc4_M, bus.rd_M, bus.mode_M} !== 106'h0) begin fails++;
      $display("FAIL flush_data: got %h %h %h %h %h want 0", bus.alu_result_M, bus.write_data_M, bus.pc4_M, bus.rd_M, bus.mode_M); end
    bus.FlushM = 0; bus.StallM = 0; bus.RD1_E = 40; bus.RD2_E = 2; tick();
    checks++; if (bus.alu_result_M !== 32'd42) begin fails++;
      $display("FAIL reload: got %h want 2a", bus.alu_result_M); end
    rst = 1; bus.StallM = 1; tick(); rst = 0;
    checks++; if ({bus.alu_result_M, bus.regWrite_M, bus.write_data_M} !== 65'h0) begin fails++;
      $display("FAIL rst_over_stall: got %h %b %h want 0", bus.alu_result_M, bus.regWrite_M, bus.write_data_M); end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_add();
    test_forward();
    test_alu();
    test_branch();
    test_jalr();
    test_stall_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
